csr_trap_rsp: RTL

- Machine-mode CSR responder: the receiving end of the trap-commit write interface (mepc/mcause/mstatus wen+wdata, already qualified by LSU valid).
- Holds mstatus, mtvec, mepc and mcause. Serves CSR-instruction reads and writes.
- After each committed ecall/mret, issues one PC-redirect request (mtvec or mepc) to the IFU over a valid/ready handshake.

---
 rtl/csr_trap_rsp.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/csr_trap_rsp.sv
// rtl/csr_trap_rsp.sv - machine-mode CSR responder for trap commits with PC-redirect handshake
//
// Holds mstatus, mtvec, mepc and mcause. It serves CSR-instruction reads and
// writes. After each committed ecall or mret, it issues one PC redirect to the IFU.
// Optional feature macro: CSR_MCYCLE_EN adds a 64-bit mcycle counter at 0xB00/0xB80.
//
// Ports:
//   i_clk, i_rst_n                    clock (rising edge), async active-low reset
//   i_mepc_wen/i_mepc_wdata           trap write of mepc
//   i_mcause_wen/i_mcause_wdata       trap write of mcause; marks an ecall commit
//   i_mstatus_wen/i_mstatus_wdata     trap write of mstatus; alone it marks an mret commit
//   i_csr_wen/i_csr_waddr/i_csr_wdata CSR-instruction write port
//   i_csr_raddr/o_csr_rdata           CSR-instruction read port (combinational)
//   o_redirect_valid/o_redirect_pc    redirect request to the IFU
//   i_redirect_ready                  IFU accepts the redirect
//   o_busy                            redirect pending
module csr_trap_rsp #(
  parameter int          DW        = 32,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_mepc_wen,
  input  logic [DW-1:0] i_mepc_wdata,
  input  logic          i_mcause_wen,
  input  logic [DW-1:0] i_mcause_wdata,
  input  logic          i_mstatus_wen,
  input  logic [DW-1:0] i_mstatus_wdata,
  input  logic          i_csr_wen,
  input  logic [11:0]   i_csr_waddr,
  input  logic [DW-1:0] i_csr_wdata,
  input  logic [11:0]   i_csr_raddr,
  output logic [DW-1:0] o_csr_rdata,
  output logic          o_redirect_valid,
  output logic [DW-1:0] o_redirect_pc,
  input  logic          i_redirect_ready,
  output logic          o_busy
);

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
`ifdef CSR_MCYCLE_EN
  localparam logic [11:0] A_MCYCLE  = 12'hB00;
  localparam logic [11:0] A_MCYCLEH = 12'hB80;
`endif

  typedef enum logic {S_IDLE, S_REDIR} state_t;

  state_t        state_q, state_d;
  // Only MIE and MPIE are stored. MPP is hardwired to 2'b11 on read.
  logic          mie_q, mie_d;
  logic          mpie_q, mpie_d;
  logic [DW-1:0] mtvec_q, mtvec_d;
  logic [DW-1:0] mepc_q, mepc_d;
  logic [DW-1:0] mcause_q, mcause_d;
  logic [DW-1:0] redirect_pc_q, redirect_pc_d;
`ifdef CSR_MCYCLE_EN
  logic [63:0]   mcycle_q, mcycle_d;
`endif

  logic idle;
  logic ecall;
  logic mret;
  logic unused_bits;

  assign unused_bits = ^{i_mstatus_wdata[DW-1:8], i_mstatus_wdata[6:4],
                         i_mstatus_wdata[2:0], i_mepc_wdata[1:0]};

  // Trap writes are only honoured in IDLE. In REDIR they are dropped as a whole.
  assign idle  = (state_q == S_IDLE);
  assign ecall = idle && i_mcause_wen;
  assign mret  = idle && i_mstatus_wen && !i_mcause_wen;

  always_comb begin
    state_d       = state_q;
    mie_d         = mie_q;
    mpie_d        = mpie_q;
    mtvec_d       = mtvec_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    redirect_pc_d = redirect_pc_q;

    // CSR-instruction writes are applied first, so trap writes below override them.
    if (i_csr_wen) begin
      case (i_csr_waddr)
        A_MSTATUS: begin
          mie_d  = i_csr_wdata[3];
          mpie_d = i_csr_wdata[7];
        end
        A_MTVEC:  mtvec_d  = {i_csr_wdata[DW-1:2], 2'b00};
        A_MEPC:   mepc_d   = {i_csr_wdata[DW-1:2], 2'b00};
        A_MCAUSE: mcause_d = i_csr_wdata;
        default: ;
      endcase
    end

    if (idle && (i_mepc_wen || i_mcause_wen)) mepc_d = {i_mepc_wdata[DW-1:2], 2'b00};
    if (ecall) mcause_d = i_mcause_wdata;
    if (idle && i_mstatus_wen) begin
      if (i_mcause_wen) begin
        mpie_d = i_mstatus_wdata[3];
        mie_d  = 1'b0;
      end else begin
        mie_d  = i_mstatus_wdata[7];
        mpie_d = 1'b1;
      end
    end

    // The redirect target is taken from the pre-edge registers. Same-cycle CSR writes
    // to mtvec or mepc therefore do not reach it.
    case (state_q)
      S_IDLE: begin
        if (ecall) begin
          redirect_pc_d = {mtvec_q[DW-1:2], 2'b00};
          state_d       = S_REDIR;
        end else if (mret) begin
          redirect_pc_d = mepc_q;
          state_d       = S_REDIR;
        end
      end
      S_REDIR: if (i_redirect_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef CSR_MCYCLE_EN
  // A write to one half replaces that half. The other half takes its own
  // incremented value, so a write to the low half gives no carry into the high half.
  always_comb begin
    mcycle_d = mcycle_q + 64'd1;
    if (i_csr_wen && i_csr_waddr == A_MCYCLE)  mcycle_d = {mcycle_q[63:32], i_csr_wdata};
    if (i_csr_wen && i_csr_waddr == A_MCYCLEH) mcycle_d = {i_csr_wdata, mcycle_q[31:0] + 32'd1};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) mcycle_q <= 64'd0;
    else          mcycle_q <= mcycle_d;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      mtvec_q       <= MTVEC_RST;
      mepc_q        <= '0;
      mcause_q      <= '0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      mie_q         <= mie_d;
      mpie_q        <= mpie_d;
      mtvec_q       <= mtvec_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  always_comb begin
    o_csr_rdata = '0;
    case (i_csr_raddr)
      A_MSTATUS: begin
        o_csr_rdata[12:11] = 2'b11;
        o_csr_rdata[7]     = mpie_q;
        o_csr_rdata[3]     = mie_q;
      end
      A_MTVEC:   o_csr_rdata = mtvec_q;
      A_MEPC:    o_csr_rdata = mepc_q;
      A_MCAUSE:  o_csr_rdata = mcause_q;
`ifdef CSR_MCYCLE_EN
      A_MCYCLE:  o_csr_rdata = mcycle_q[31:0];
      A_MCYCLEH: o_csr_rdata = mcycle_q[63:32];
`endif
      default:   o_csr_rdata = '0;
    endcase
  end

  assign o_redirect_valid = (state_q == S_REDIR);
  assign o_busy           = (state_q == S_REDIR);
  assign o_redirect_pc    = redirect_pc_q;

endmodule
